pulse_timestamp_fifo: RTL and testbench
=======================================

# pulse_timestamp_fifo

Timestamps single-cycle event pulses already synchronized into the fast_clk domain and buffers the timestamps for a consumer. It sits directly downstream of the slow-to-fast pulse synchronizer: each fast_clk-domain pulse it receives captures the value of a free-running cycle counter. The captured value is queued in a small FIFO and drained through a valid/ready interface. Overflow events are counted, not silently lost.

## Interface
- TS_W, 16: timestamp counter width, in bits.
- DEPTH, 8: FIFO entries; must be a power of two, at least 2.
- OVF_W, 8: overflow counter width, in bits.

- fast_clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- pulse_in  in  1  single-cycle event pulse, already synchronous to fast_clk.
- ts_valid  out  1  head entry available.
- ts_ready  in  1  consumer accepts head entry when ts_valid && ts_ready.
- ts_data  out  TS_W  timestamp of head entry.
- ts_level  out  $clog2(DEPTH)+1  current number of stored entries.
- clear_ovf  in  1  synchronous clear of overflow_cnt and overflow.
- overflow_cnt  out  OVF_W  count of dropped pulses; saturates at all-ones.
- overflow  out  1  sticky flag: at least one pulse dropped since last clear or reset.

## Operation
- Timestamp counter:
  - Free-running, TS_W bits.
  - 0 in the first cycle after reset release; +1 every cycle.
  - Wraps from 2^TS_W-1 to 0 with no flag.
- Capture: a cycle with pulse_in=1 pushes the counter value of that same cycle.
- Back-to-back pulses, one per cycle, are each captured. No minimum spacing is required.
- Pop: occurs on ts_valid && ts_ready.
- Push/pop decision for each cycle with pulse_in=1:
  - Not full: push.
  - Full with pop in the same cycle: push and pop both occur; level stays DEPTH.
  - Full without pop: the pulse is dropped. overflow_cnt increments, saturating; overflow is set.
- Empty with a push: no bypass. The entry becomes visible the next cycle.
- Order is strict FIFO.
- Read/write pointers are $clog2(DEPTH)+1 bits wide. The MSB distinguishes full from empty.
- clear_ovf=1 sets overflow_cnt=0 and overflow=0 next cycle.
  - A drop in the same cycle wins: the result is overflow_cnt=1 and overflow=1.
- ts_data is undefined-but-stable when ts_valid=0. The bench must not check it then.
- Reset at any time:
  - Empties the FIFO.
  - Zeroes the counter, overflow_cnt and overflow.
  - In-flight entries are discarded.

## Timing
- Reset values: ts_valid=0, ts_data=0, ts_level=0, overflow_cnt=0, overflow=0.
- Push latency:
  - pulse_in high in cycle t gives ts_valid=1 in cycle t+1, when the FIFO was empty.
  - ts_level reflects the push in cycle t+1.
- Pop: the handshake in cycle t presents the next entry, or ts_valid=0, in cycle t+1.
- Hold: while ts_valid && !ts_ready, ts_data and ts_valid hold stable.
- Throughput:
  - One push and one pop per cycle, simultaneously.
  - Sustained one pulse per cycle with ts_ready=1 never drops.
- No combinational path from pulse_in or ts_ready to any output. All outputs are registered or direct decodes of registered state.

## Structure
- Package pulse_ts_pkg:
  - Default values for TS_W, DEPTH, OVF_W.
  - A typedef for the timestamp word.
  - A localparam function computing pointer width from DEPTH.
- Sub-module sync_fifo:
  - Parameterized width/depth, single-clock, first-word-fall-through.
  - Ports: push, pop, wdata, rdata, full, empty, level.
- The top-level contains:
  - The timestamp counter.
  - The push-enable logic, which handles the full-with-simultaneous-pop case.
  - The overflow counter and sticky flag.

## Test plan
- Reset release, ts_ready=0, single pulse at counter=5 → ts_valid=1 the next cycle, ts_data=5, ts_level=1. Raise ts_ready for one cycle → ts_valid=0, ts_level=0.
- DEPTH=8, ts_ready=0, 10 pulses on consecutive cycles starting at counter=20 → ts_level=8, overflow_cnt=2, overflow=1. Draining yields 20..27 in order.
- FIFO full and ts_ready=1 while a pulse arrives at counter=40 → no drop, ts_level stays 8, overflow_cnt unchanged. 40 appears last in the drain.
- Counter preloaded via long idle so pulses land at 65534, 65535, 0 (TS_W=16) → read order is 65534, 65535, 0.
- overflow_cnt at 255 with another drop → stays 255. Then clear_ovf coincident with a drop → next cycle overflow_cnt=1, overflow=1.
- Assert rst_n low mid-drain with 4 entries queued → ts_valid=0, ts_level=0, overflow=0 immediately, without waiting for a clock. After release, the first pulse at counter=3 reads back 3.

Source files
------------

// File: rtl/pulse_ts_pkg.sv
// Shared defaults and helpers for the pulse timestamp FIFO.
// Pointer width keeps one extra bit to tell full from empty.
package pulse_ts_pkg;

  localparam int TS_W_DEF  = 16;
  localparam int DEPTH_DEF = 8;
  localparam int OVF_W_DEF = 8;

  typedef logic [TS_W_DEF-1:0] ts_t;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
// Head entry is a direct read of registered storage.
module sync_fifo
  import pulse_ts_pkg::*;
#(
  parameter  int WIDTH = TS_W_DEF,
  parameter  int DEPTH = DEPTH_DEF,
  localparam int AW    = $clog2(DEPTH),
  localparam int PW    = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [PW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;
  assign rdata = mem[rd_ptr[AW-1:0]];

  assign do_pop  = pop && !empty;
  // A pop frees the slot the push is about to take.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

endmodule

// File: rtl/pulse_timestamp_fifo.sv
// Captures a free-running cycle count on each pulse and queues it.
// Dropped pulses are counted in a saturating counter with sticky flag.
module pulse_timestamp_fifo
  import pulse_ts_pkg::*;
#(
  parameter int TS_W  = TS_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int OVF_W = OVF_W_DEF
) (
  input  logic                      fast_clk,
  input  logic                      rst_n,
  input  logic                      pulse_in,
  output logic                      ts_valid,
  input  logic                      ts_ready,
  output logic [TS_W-1:0]           ts_data,
  output logic [ptr_w(DEPTH)-1:0]   ts_level,
  input  logic                      clear_ovf,
  output logic [OVF_W-1:0]          overflow_cnt,
  output logic                      overflow
);

  logic [TS_W-1:0] ts_cnt;
  logic            full;
  logic            empty;
  logic            pop;
  logic            push;
  logic            drop;

  assign ts_valid = !empty;
  assign pop      = !empty && ts_ready;
  assign push     = pulse_in && (!full || pop);
  assign drop     = pulse_in && full && !pop;

  always_ff @(posedge fast_clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_cnt <= '0;
    end else begin
      ts_cnt <= ts_cnt + TS_W'(1);
    end
  end

  // A drop coinciding with a clear leaves exactly that one drop counted.
  always_ff @(posedge fast_clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_cnt <= '0;
      overflow     <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clear_ovf) begin
        overflow_cnt <= OVF_W'(1);
      end else if (~&overflow_cnt) begin
        overflow_cnt <= overflow_cnt + OVF_W'(1);
      end
    end else if (clear_ovf) begin
      overflow_cnt <= '0;
      overflow     <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH (TS_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (fast_clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (ts_cnt),
    .rdata (ts_data),
    .full  (full),
    .empty (empty),
    .level (ts_level)
  );

endmodule

// File: tb/tb_pulse_timestamp_fifo.sv
// Randomized bench for pulse_timestamp_fifo with a queue-based model.
// Directed scenarios pin the model with hand-computed values.
module tb_pulse_timestamp_fifo;
  import pulse_ts_pkg::*;

  localparam int DEPTH = 8;

  logic        fast_clk;
  logic        rst_n;
  logic        pulse_in;
  logic        ts_valid;
  logic        ts_ready;
  logic [15:0] ts_data;
  logic [3:0]  ts_level;
  logic        clear_ovf;
  logic [7:0]  overflow_cnt;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  ts_t q[$];
  ts_t m_cnt = '0;
  int  m_ocnt = 0;
  bit  m_ovf = 0;

  pulse_timestamp_fifo #(
    .TS_W  (16),
    .DEPTH (DEPTH),
    .OVF_W (8)
  ) dut (
    .fast_clk     (fast_clk),
    .rst_n        (rst_n),
    .pulse_in     (pulse_in),
    .ts_valid     (ts_valid),
    .ts_ready     (ts_ready),
    .ts_data      (ts_data),
    .ts_level     (ts_level),
    .clear_ovf    (clear_ovf),
    .overflow_cnt (overflow_cnt),
    .overflow     (overflow)
  );

  initial fast_clk = 0;
  always #5 fast_clk = ~fast_clk;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_cnt  = '0;
    m_ocnt = 0;
    m_ovf  = 0;
  endtask

  task automatic model_step();
    bit pop;
    bit drop;
    if (!rst_n) begin
      model_reset();
      return;
    end
    pop  = (q.size() != 0) && ts_ready;
    drop = pulse_in && (q.size() == DEPTH) && !pop;
    if (pop) void'(q.pop_front());
    if (pulse_in && !drop) q.push_back(m_cnt);
    if (drop) begin
      m_ovf  = 1;
      m_ocnt = clear_ovf ? 1 : ((m_ocnt == 255) ? 255 : m_ocnt + 1);
    end else if (clear_ovf) begin
      m_ocnt = 0;
      m_ovf  = 0;
    end
    m_cnt = m_cnt + 16'd1;
  endtask

  task automatic cyc(input bit p, input bit r, input bit c);
    pulse_in  = p;
    ts_ready  = r;
    clear_ovf = c;
    @(posedge fast_clk);
    model_step();
    #1;
  endtask

  task automatic idle_until(input int v, input bit r);
    int n;
    n = 0;
    while (int'(m_cnt) != v && n < 70000) begin
      cyc(0, r, 0);
      n++;
    end
    chk("idle_until_bound", int'(m_cnt), v);
  endtask

  always @(negedge fast_clk) begin
    if (chk_en) begin
      chk("ts_valid", int'(ts_valid), int'(q.size() != 0));
      if (q.size() != 0) chk("ts_data", int'(ts_data), int'(q[0]));
      chk("ts_level", int'(ts_level), q.size());
      chk("overflow_cnt", int'(overflow_cnt), m_ocnt);
      chk("overflow", int'(overflow), int'(m_ovf));
    end
  end

  initial begin
    int exp_a[8];
    int exp_w[3];
    rst_n     = 0;
    pulse_in  = 0;
    ts_ready  = 0;
    clear_ovf = 0;
    chk_en    = 1;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("rst_valid", int'(ts_valid), 0);
    chk("rst_data", int'(ts_data), 0);
    chk("rst_level", int'(ts_level), 0);
    chk("rst_ocnt", int'(overflow_cnt), 0);
    chk("rst_ovf", int'(overflow), 0);
    rst_n = 1;

    idle_until(5, 0);
    cyc(1, 0, 0);
    chk("single_valid", int'(ts_valid), 1);
    chk("single_data", int'(ts_data), 5);
    chk("single_level", int'(ts_level), 1);
    cyc(0, 1, 0);
    chk("single_pop_valid", int'(ts_valid), 0);
    chk("single_pop_level", int'(ts_level), 0);

    idle_until(20, 0);
    for (int i = 0; i < 10; i++) cyc(1, 0, 0);
    chk("fill_level", int'(ts_level), 8);
    chk("fill_ocnt", int'(overflow_cnt), 2);
    chk("fill_ovf", int'(overflow), 1);
    idle_until(40, 0);
    chk("full_head", int'(ts_data), 20);
    cyc(1, 1, 0);
    chk("fullpop_level", int'(ts_level), 8);
    chk("fullpop_ocnt", int'(overflow_cnt), 2);
    exp_a = '{21, 22, 23, 24, 25, 26, 27, 40};
    for (int i = 0; i < 8; i++) begin
      chk("drain_data", int'(ts_data), exp_a[i]);
      cyc(0, 1, 0);
    end
    chk("drain_empty", int'(ts_valid), 0);
    cyc(0, 0, 1);
    chk("clear_ocnt", int'(overflow_cnt), 0);
    chk("clear_ovf", int'(overflow), 0);

    for (int i = 0; i < 2000; i++) begin
      cyc($urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
          $urandom_range(0, 99) < 3);
    end
    for (int i = 0; i < 10; i++) cyc(0, 1, 1);

    idle_until(65534, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0);
    exp_w = '{65534, 65535, 0};
    for (int i = 0; i < 3; i++) begin
      chk("wrap_data", int'(ts_data), exp_w[i]);
      cyc(0, 1, 0);
    end

    for (int i = 0; i < 8; i++) cyc(1, 0, 0);
    for (int i = 0; i < 256; i++) cyc(1, 0, 0);
    chk("sat_ocnt", int'(overflow_cnt), 255);
    chk("sat_ovf", int'(overflow), 1);
    cyc(1, 0, 1);
    chk("clrdrop_ocnt", int'(overflow_cnt), 1);
    chk("clrdrop_ovf", int'(overflow), 1);

    for (int i = 0; i < 4; i++) cyc(0, 1, 0);
    chk("pre_rst_level", int'(ts_level), 4);
    #2;
    rst_n = 0;
    model_reset();
    #1;
    chk("async_valid", int'(ts_valid), 0);
    chk("async_level", int'(ts_level), 0);
    chk("async_ovf", int'(overflow), 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    rst_n = 1;
    idle_until(3, 0);
    cyc(1, 0, 0);
    chk("post_rst_valid", int'(ts_valid), 1);
    chk("post_rst_data", int'(ts_data), 3);
    cyc(0, 1, 0);
    cyc(0, 0, 0);

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
